multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Main control FSM for the multicycle RV32I datapath.
- Generates the write-enable strobes that drive the en inputs of the 32-bit enabled registers (PC, IR, OldPC, Data), plus register-file and memory write controls, datapath mux selects and the ALU control code.
- Sits directly upstream of those registers. Consumes instruction fields from the IR and the ALU zero flag.

Parameters:
- STATE_W, 4, width of state register and of state_o.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- op  in  7  instr[6:0].
- funct3  in  3  instr[14:12].
- funct7b5  in  1  instr[30].
- zero  in  1  ALU zero flag, same cycle.
- pc_write  out  1  enable for PC register.
- ir_write  out  1  enable for IR and OldPC registers.
- adr_src  out  1  memory address mux: 0=PC, 1=Result.
- mem_write  out  1  data memory write strobe.
- reg_write  out  1  register file write enable.
- result_src  out  2  00=ALUOut, 01=Data, 10=ALUResult.
- alu_src_a  out  2  00=PC, 01=OldPC, 10=rs1 register A.
- alu_src_b  out  2  00=rs2 WriteData, 01=ImmExt, 10=constant 4.
- alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
- illegal  out  1  high while in ILLEGAL state.
- state_o  out  STATE_W  current state encoding, for debug.

Behaviour:
- Reset and clocking
  - rst is asynchronous: while high, state=FETCH immediately. Clock edges are ignored while rst is high.
  - First rising edge after rst deasserts executes FETCH.
- Output types
  - All outputs except pc_write are Moore, decoded from state only.
  - pc_write = pc_update | (branch & zero). It is combinational on zero in BEQ.
  - Any control not listed for a state is 0.
- Reset values (FETCH decode): ir_write=1, pc_write=1, adr_src=0, mem_write=0, reg_write=0, result_src=10, alu_src_a=00, alu_src_b=10, alu_control=000, illegal=0, state_o=0.
  - Downstream registers share rst, so these enables are harmless during reset.
- State encodings (state_o): FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, JAL=9, BEQ=10, ILLEGAL=11. Codes 12..15 are unreachable; if entered, go to FETCH.
- Per-state outputs and next state:
  - FETCH: ir_write=1, pc_update=1, adr_src=0, alu_src_a=00, alu_src_b=10, aluop=00, result_src=10. Next: DECODE.
  - DECODE: alu_src_a=01, alu_src_b=01, aluop=00 (branch target precompute). Next state by op:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECUTER
    - 0010011 -> EXECUTEI
    - 1101111 -> JAL
    - 1100011 -> BEQ
    - any other -> ILLEGAL
  - MEMADR: alu_src_a=10, alu_src_b=01, aluop=00. Next: MEMREAD if op=0000011, else MEMWRITE.
  - MEMREAD: result_src=00, adr_src=1. Next: MEMWB.
  - MEMWB: result_src=01, reg_write=1. Next: FETCH.
  - MEMWRITE: result_src=00, adr_src=1, mem_write=1. Next: FETCH.
  - EXECUTER: alu_src_a=10, alu_src_b=00, aluop=10. Next: ALUWB.
  - EXECUTEI: alu_src_a=10, alu_src_b=01, aluop=10. Next: ALUWB.
  - ALUWB: result_src=00, reg_write=1. Next: FETCH.
  - JAL: alu_src_a=01, alu_src_b=10, aluop=00, result_src=00, pc_update=1. Next: ALUWB.
  - BEQ: alu_src_a=10, alu_src_b=00, aluop=01, result_src=00, branch=1. Next: FETCH.
  - ILLEGAL: all enables 0, illegal=1. Remains until rst.
- ALU decode (internal aluop, 2 bits):
  - aluop 00 -> add. aluop 01 -> sub.
  - aluop 10, by funct3:
    - 000 -> sub if (op[5] & funct7b5), else add (addi with instr[30]=1 stays add)
    - 010 -> slt
    - 110 -> or
    - 111 -> and
    - other -> add
  - aluop 11 -> add.
- Instruction latency in cycles: lw 5, sw 4, R-type 4, I-ALU 4, jal 4, beq 3.
- Mid-instruction: op/funct changes outside DECODE/MEMADR/EXECUTE have no effect on the state sequence. Fields are sampled only where listed.
- Reset mid-instruction: rst in any state -> FETCH asynchronously. No partial write strobe persists after rst rises.

Test Plan:
- Reset: assert rst mid-MEMWRITE -> state_o=0 and mem_write=0 immediately. After release, state sequence is 0,1,... with ir_write=1 only in FETCH.
- lw (op=0000011): states 0,1,2,3,4,0. reg_write=1 only in state 4 with result_src=01. adr_src=1 in state 3.
- sw (op=0100011): states 0,1,2,5,0. mem_write=1 exactly one cycle (state 5). reg_write never 1.
- R-type sub (op=0110011, funct3=000, funct7b5=1): alu_control=001 in EXECUTER. addi with funct7b5=1 -> 000 in EXECUTEI. or -> 011, and -> 010, slt -> 101.
- beq: zero=1 in BEQ -> pc_write=1. zero=0 -> pc_write=0. Toggling zero in other states never changes pc_write.
- jal: states 0,1,9,8,0. pc_write=1 in 9, reg_write=1 in 8. Illegal op=1111111 -> state 11, illegal=1, all enables 0 for 10+ cycles until rst.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle RV32I datapath.
// Moore control decode per state; pc_write also follows the ALU zero flag in BEQ.
module multicycle_ctrl #(
   parameter int STATE_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [6:0]         op,
   input  logic [2:0]         funct3,
   input  logic               funct7b5,
   input  logic               zero,
   output logic               pc_write,
   output logic               ir_write,
   output logic               adr_src,
   output logic               mem_write,
   output logic               reg_write,
   output logic [1:0]         result_src,
   output logic [1:0]         alu_src_a,
   output logic [1:0]         alu_src_b,
   output logic [2:0]         alu_control,
   output logic               illegal,
   output logic [STATE_W-1:0] state_o
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_JAL      = 4'd9,
      S_BEQ      = 4'd10,
      S_ILLEGAL  = 4'd11
   } state_t;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_BEQ = 7'b1100011;

   state_t     state_q, state_d;
   logic       pc_update;
   logic       branch;
   logic [1:0] aluop;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_FETCH;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d    = S_FETCH;
      pc_update  = 1'b0;
      branch     = 1'b0;
      aluop      = 2'b00;
      ir_write   = 1'b0;
      adr_src    = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      result_src = 2'b00;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      illegal    = 1'b0;
      case (state_q)
         S_FETCH: begin
            ir_write   = 1'b1;
            pc_update  = 1'b1;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            state_d    = S_DECODE;
         end
         S_DECODE: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
            if (op == OP_LW || op == OP_SW) state_d = S_MEMADR;
            else if (op == OP_R)            state_d = S_EXECR;
            else if (op == OP_I)            state_d = S_EXECI;
            else if (op == OP_JAL)          state_d = S_JAL;
            else if (op == OP_BEQ)          state_d = S_BEQ;
            else                            state_d = S_ILLEGAL;
         end
         S_MEMADR: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            state_d   = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            adr_src = 1'b1;
            state_d = S_MEMWB;
         end
         S_MEMWB: begin
            result_src = 2'b01;
            reg_write  = 1'b1;
         end
         S_MEMWRITE: begin
            adr_src   = 1'b1;
            mem_write = 1'b1;
         end
         S_EXECR: begin
            alu_src_a = 2'b10;
            aluop     = 2'b10;
            state_d   = S_ALUWB;
         end
         S_EXECI: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            aluop     = 2'b10;
            state_d   = S_ALUWB;
         end
         S_ALUWB: reg_write = 1'b1;
         S_JAL: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b10;
            pc_update = 1'b1;
            state_d   = S_ALUWB;
         end
         S_BEQ: begin
            alu_src_a = 2'b10;
            aluop     = 2'b01;
            branch    = 1'b1;
         end
         S_ILLEGAL: begin
            illegal = 1'b1;
            state_d = S_ILLEGAL;
         end
         default: state_d = S_FETCH;
      endcase
   end

   // Only R-type sub sets instr[30]; addi with that bit set must still add.
   always_comb begin
      alu_control = 3'b000;
      if (aluop == 2'b01) begin
         alu_control = 3'b001;
      end else if (aluop == 2'b10) begin
         case (funct3)
            3'b000:  alu_control = (op[5] & funct7b5) ? 3'b001 : 3'b000;
            3'b010:  alu_control = 3'b101;
            3'b110:  alu_control = 3'b011;
            3'b111:  alu_control = 3'b010;
            default: alu_control = 3'b000;
         endcase
      end
   end

   assign pc_write = pc_update | (branch & zero);
   assign state_o  = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed and random instructions
// checked against a per-instruction cycle table model.
module tb_multicycle_ctrl;

   typedef struct packed {
      logic       pcw;
      logic       irw;
      logic       adr;
      logic       memw;
      logic       regw;
      logic [1:0] rs;
      logic [1:0] sa;
      logic [1:0] sb;
      logic [2:0] alu;
      logic       ill;
      logic [3:0] st;
   } ctl_t;

   localparam logic [6:0] LW  = 7'b0000011;
   localparam logic [6:0] SW  = 7'b0100011;
   localparam logic [6:0] RT  = 7'b0110011;
   localparam logic [6:0] IT  = 7'b0010011;
   localparam logic [6:0] JAL = 7'b1101111;
   localparam logic [6:0] BEQ = 7'b1100011;
   localparam logic [6:0] BAD = 7'b1111111;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       zero;
   logic       pc_write, ir_write, adr_src, mem_write, reg_write;
   logic [1:0] result_src, alu_src_a, alu_src_b;
   logic [2:0] alu_control;
   logic       illegal;
   logic [3:0] state_o;
   ctl_t       obs;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   multicycle_ctrl #(.STATE_W(4)) dut (
      .clk(clk), .rst(rst), .op(op), .funct3(funct3),
      .funct7b5(funct7b5), .zero(zero),
      .pc_write(pc_write), .ir_write(ir_write), .adr_src(adr_src),
      .mem_write(mem_write), .reg_write(reg_write),
      .result_src(result_src), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .alu_control(alu_control),
      .illegal(illegal), .state_o(state_o)
   );

   assign obs = {pc_write, ir_write, adr_src, mem_write, reg_write,
                 result_src, alu_src_a, alu_src_b, alu_control,
                 illegal, state_o};

   function automatic logic [2:0] alu_fn(logic [6:0] o, logic [2:0] f3,
                                         logic f7);
      case (f3)
         3'b000:  return (o == RT && f7) ? 3'b001 : 3'b000;
         3'b010:  return 3'b101;
         3'b110:  return 3'b011;
         3'b111:  return 3'b010;
         default: return 3'b000;
      endcase
   endfunction

   // Expected controls for one cycle of an instruction at step code st.
   function automatic ctl_t model(int st, logic [6:0] o, logic [2:0] f3,
                                  logic f7, logic z);
      ctl_t c = '0;
      c.st = st[3:0];
      case (st)
         0:  begin c.irw = 1; c.pcw = 1; c.rs = 2; c.sb = 2; end
         1:  begin c.sa = 1; c.sb = 1; end
         2:  begin c.sa = 2; c.sb = 1; end
         3:  c.adr = 1;
         4:  begin c.rs = 1; c.regw = 1; end
         5:  begin c.adr = 1; c.memw = 1; end
         6:  begin c.sa = 2; c.alu = alu_fn(o, f3, f7); end
         7:  begin c.sa = 2; c.sb = 1; c.alu = alu_fn(o, f3, f7); end
         8:  c.regw = 1;
         9:  begin c.sa = 1; c.sb = 2; c.pcw = 1; end
         10: begin c.sa = 2; c.alu = 3'b001; c.pcw = z; end
         11: c.ill = 1;
         default: c = '0;
      endcase
      return c;
   endfunction

   function automatic void build_seq(logic [6:0] o, ref int q[$]);
      q = '{0, 1};
      case (o)
         LW:      q = {q, 2, 3, 4};
         SW:      q = {q, 2, 5};
         RT:      q = {q, 6, 8};
         IT:      q = {q, 7, 8};
         JAL:     q = {q, 9, 8};
         BEQ:     q = {q, 10};
         default: for (int i = 0; i < 12; i++) q.push_back(11);
      endcase
   endfunction

   task automatic chk(string tag, ctl_t exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Runs one instruction; nsteps < 0 runs it fully and leaves time just
   // after the negedge that starts the next instruction.
   task automatic run_instr(logic [6:0] o, logic [2:0] f3, logic f7,
                            int nsteps);
      int  q[$];
      int  n;
      bit  held;
      build_seq(o, q);
      n = (nsteps < 0) ? q.size() : nsteps;
      for (int i = 0; i < n; i++) begin
         held = (q[i] == 1 || q[i] == 2 || q[i] == 6 || q[i] == 7);
         op       = held ? o  : 7'($urandom);
         funct3   = held ? f3 : 3'($urandom);
         funct7b5 = held ? f7 : 1'($urandom);
         zero     = 1'($urandom);
         #1;
         chk($sformatf("op%b_st%0d", o, q[i]),
             model(q[i], o, f3, f7, zero));
         if (q[i] == 10) begin
            zero = ~zero;
            #1;
            chk("beq_zero_flip", model(10, o, f3, f7, zero));
         end
         if (nsteps < 0 || i < n - 1) @(negedge clk);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      chk("rst_async", model(0, '0, '0, 1'b0, 1'b0));
      @(negedge clk);
      zero = 1'b1;
      #1;
      chk("rst_hold", model(0, '0, '0, 1'b0, 1'b0));
      rst = 1'b0;
   endtask

   initial begin
      logic [6:0] ops [6];
      ops = '{LW, SW, RT, IT, JAL, BEQ};
      rst = 1'b1;
      op = '0;
      funct3 = '0;
      funct7b5 = 1'b0;
      zero = 1'b0;
      @(negedge clk);
      do_reset();

      run_instr(LW,  3'b010, 1'b0, -1);
      run_instr(SW,  3'b010, 1'b1, -1);
      run_instr(RT,  3'b000, 1'b1, -1);
      run_instr(IT,  3'b000, 1'b1, -1);
      run_instr(RT,  3'b110, 1'b0, -1);
      run_instr(RT,  3'b111, 1'b0, -1);
      run_instr(IT,  3'b010, 1'b0, -1);
      run_instr(BEQ, 3'b000, 1'b0, -1);
      run_instr(JAL, 3'b000, 1'b0, -1);

      run_instr(SW, 3'b010, 1'b0, 4);
      do_reset();

      for (int k = 0; k < 60; k++) begin
         run_instr(ops[$urandom_range(0, 5)], 3'($urandom),
                   1'($urandom), -1);
      end

      run_instr(BAD, 3'b000, 1'b0, 14);
      do_reset();
      run_instr(LW, 3'b010, 1'b0, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
